card_display_ctrl: RTL and testbench
====================================

# card_display_ctrl

Multi-digit card display controller for the Baccarat datapath. Latches 4-bit card codes (0 = none, 1 = A … 10, 11 = J, 12 = Q, 13 = K) into NUM_DIGITS independent display slots. Each newly loaded card plays a short reveal animation, and winning-hand slots can be blinked. Sits between the card-dealing datapath and the HEX outputs, replacing per-digit combinational decoders with registered, stateful outputs.

## Interface
- NUM_DIGITS, 6: number of display slots (1–16)
- REVEAL_CYCLES, 4: cycles a freshly loaded slot shows the dash glyph (0 = no reveal)
- BLINK_DIV, 24: width of the free-running blink counter; its MSB is the blink phase
- SEG_ACTIVE_LOW, 1: 1 = segment lit by 0 (DE1 HEX); 0 = all glyphs inverted
- slow_clock  in  1  sole clock
- resetb  in  1  asynchronous, active-low reset
- load  in  1  single-cycle strobe: write load_card into slot load_idx
- load_idx  in  $clog2(NUM_DIGITS) (min 1)  target slot
- load_card  in  4  card code
- clear  in  1  return all slots to EMPTY
- blink_mask  in  NUM_DIGITS  per-slot blink enable; bit i = slot i
- seg_out  out  7*NUM_DIGITS  slot i on bits [7i+6:7i]; bit order {g,f,e,d,c,b,a}
- digit_valid  out  NUM_DIGITS  slot i is in SHOW with a code in 1–13
- busy  out  1  any slot in REVEAL

## Operation
- Each slot has a 4-bit card register, a state (EMPTY, REVEAL, SHOW) and a reveal down-counter.
- Slot transitions:
  - EMPTY/REVEAL/SHOW → REVEAL on load to this slot, with counter = REVEAL_CYCLES-1. If REVEAL_CYCLES = 0, the slot goes directly to SHOW.
  - REVEAL → SHOW when the counter = 0; otherwise the counter decrements.
  - Any state → EMPTY on clear.
- Priority and edge cases:
  - clear beats load in the same cycle.
  - Reloading a slot in REVEAL or SHOW restarts the reveal.
  - load with load_idx ≥ NUM_DIGITS is ignored; no state changes.
- Glyph per slot (active-low values shown):
  - EMPTY → blank 1111111.
  - REVEAL → dash 0111111.
  - SHOW → decoded card: 1 0001000, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000, 10 1000000, J 1100001, Q 0011000, K 0001001.
  - Codes 0, 14 and 15 decode to blank.
- Blink:
  - The blink counter free-runs from reset and wraps at 2^BLINK_DIV. clear does not reset it.
  - When the counter MSB = 1, a SHOW slot with its blink_mask bit set displays blank.
  - blink_mask has no effect on REVEAL or EMPTY slots.
- SEG_ACTIVE_LOW = 0 inverts every glyph bit.

## Timing
- Reset values:
  - All slots EMPTY, card registers 0, counters 0, blink counter 0.
  - seg_out = blank on all slots (all 1s if active-low, all 0s otherwise).
  - digit_valid = 0, busy = 0.
- State updates on the rising edge of slow_clock in which load or clear is sampled.
- digit_valid and busy are combinational from state, so they change in the same cycle as the state.
- seg_out is registered from state, card and blink phase, adding 1 cycle of latency.
- Load sampled at edge k with REVEAL_CYCLES = R ≥ 1:
  - busy is high after edges k … k+R-1.
  - seg_out shows the dash after edges k+1 … k+R.
  - seg_out shows the card value from edge k+R+1.
  - digit_valid rises after edge k+R.
- R = 0: the value appears on seg_out after edge k+1.
- Independent slots may be loaded on consecutive cycles; each reveal runs concurrently.
- Deassertion of resetb mid-reveal is not special; the block restarts from the reset state.

## Structure
- card_disp_pkg holds:
  - the slot_state_t enum (EMPTY, REVEAL, SHOW);
  - active-low glyph constants GLYPH_BLANK and GLYPH_DASH;
  - the card-code localparams (CARD_NONE, CARD_J, CARD_Q, CARD_K).
- One combinational sub-module, card_glyph_decode (4-bit code → 7-bit active-low glyph), instantiated once per slot in a generate loop.
- Polarity inversion and blink gating are done in the top module.

## Test plan
- Reset: hold resetb = 0, then release → all seg_out = 7'b1111111, digit_valid = 0, busy = 0.
- Load with NUM_DIGITS = 6, R = 4: load slot 2 with card 12 → slot 2 shows 0111111 for 4 cycles, then 0011000. busy is high for 4 cycles. digit_valid[2] rises with the state. Other slots stay blank.
- Out-of-range index and invalid code:
  - Load idx 7 → no change.
  - Load slot 0 with card 14 → blank after the reveal, with digit_valid[0] = 0.
- Clear priority: clear and load (slot 1, card 5) in the same cycle → slot 1 stays blank. Separately, load slot 1 with card 5, wait 2 cycles, then reload slot 1 with card 13 → the reveal restarts and the slot ends showing 0001001.
- Blink: BLINK_DIV = 3, slot 3 in SHOW with card 1, blink_mask = 6'b001000 → slot 3 alternates 0001000 / 1111111 every 4 cycles. An unmasked slot is steady.
- Polarity: SEG_ACTIVE_LOW = 0, R = 0, load card 8 → 7'b1111111 on the next cycle. Empty slots read 7'b0000000.

Source files
------------

// File: rtl/card_disp_pkg.sv
// Shared types and constants for the card display controller.
// Glyphs are stored active-low, {g,f,e,d,c,b,a}.
package card_disp_pkg;

  typedef enum logic [1:0] {
    StEmpty,
    StReveal,
    StShow
  } slot_state_t;

  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;

  localparam logic [3:0] CARD_NONE = 4'd0;
  localparam logic [3:0] CARD_J    = 4'd11;
  localparam logic [3:0] CARD_Q    = 4'd12;
  localparam logic [3:0] CARD_K    = 4'd13;

  function automatic logic card_is_valid(input logic [3:0] code);
    return (code != CARD_NONE) && (code <= CARD_K);
  endfunction

endpackage

// File: rtl/card_glyph_decode.sv
// Card code to active-low seven-segment glyph; unused codes decode to blank.
module card_glyph_decode
  import card_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_BLANK;
    unique case (code)
      4'd1:    glyph = 7'b0001000;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      4'd10:   glyph = 7'b1000000;
      CARD_J:  glyph = 7'b1100001;
      CARD_Q:  glyph = 7'b0011000;
      CARD_K:  glyph = 7'b0001001;
      default: glyph = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/card_display_ctrl.sv
// Multi-slot card display: per-slot reveal animation, blink gating and
// registered seven-segment outputs.
module card_display_ctrl
  import card_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 6,
  parameter int unsigned REVEAL_CYCLES  = 4,
  parameter int unsigned BLINK_DIV      = 24,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int unsigned CNT_W = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1
) (
  input  logic                    slow_clock,
  input  logic                    resetb,
  input  logic                    load,
  input  logic [IDX_W-1:0]        load_idx,
  input  logic [3:0]              load_card,
  input  logic                    clear,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7*NUM_DIGITS-1:0] seg_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    busy
);

  localparam logic [7*NUM_DIGITS-1:0] SEG_RESET = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

  slot_state_t      state_q [NUM_DIGITS];
  slot_state_t      state_d [NUM_DIGITS];
  logic [3:0]       card_q  [NUM_DIGITS];
  logic [3:0]       card_d  [NUM_DIGITS];
  logic [CNT_W-1:0] cnt_q   [NUM_DIGITS];
  logic [CNT_W-1:0] cnt_d   [NUM_DIGITS];
  logic [6:0]       dec_glyph [NUM_DIGITS];

  logic [BLINK_DIV-1:0]    blink_q;
  logic [7*NUM_DIGITS-1:0] seg_d, seg_q;
  logic                    blink_phase;

  assign blink_phase = blink_q[BLINK_DIV-1];

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      state_d[i] = state_q[i];
      card_d[i]  = card_q[i];
      cnt_d[i]   = cnt_q[i];
      if (clear) begin
        state_d[i] = StEmpty;
        card_d[i]  = CARD_NONE;
        cnt_d[i]   = '0;
      end else if (load && (load_idx == IDX_W'(i))) begin
        // Any load restarts the reveal, even on a slot already showing.
        card_d[i] = load_card;
        if (REVEAL_CYCLES == 0) begin
          state_d[i] = StShow;
          cnt_d[i]   = '0;
        end else begin
          state_d[i] = StReveal;
          cnt_d[i]   = CNT_W'(REVEAL_CYCLES - 1);
        end
      end else if (state_q[i] == StReveal) begin
        if (cnt_q[i] == '0) begin
          state_d[i] = StShow;
        end else begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        state_q[i] <= StEmpty;
        card_q[i]  <= CARD_NONE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        state_q[i] <= state_d[i];
        card_q[i]  <= card_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Free-running; clear deliberately leaves it alone so blink stays in phase.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_q + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : gen_dec
    card_glyph_decode u_dec (
      .code  (card_q[g]),
      .glyph (dec_glyph[g])
    );
  end

  always_comb begin
    seg_d       = SEG_RESET;
    digit_valid = '0;
    busy        = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      logic [6:0] raw;
      raw = GLYPH_BLANK;
      unique case (state_q[i])
        StEmpty:  raw = GLYPH_BLANK;
        StReveal: raw = GLYPH_DASH;
        StShow:   raw = (blink_mask[i] && blink_phase) ? GLYPH_BLANK : dec_glyph[i];
        default:  raw = GLYPH_BLANK;
      endcase
      seg_d[7*i +: 7] = (SEG_ACTIVE_LOW != 0) ? raw : ~raw;
      digit_valid[i]  = (state_q[i] == StShow) && card_is_valid(card_q[i]);
      busy            = busy | (state_q[i] == StReveal);
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      seg_q <= SEG_RESET;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign seg_out = seg_q;

endmodule

// File: tb/tb_card_display_ctrl.sv
// Scoreboard bench: expected per-cycle outputs are queued as stimulus is
// driven, then popped and compared one clock at a time.
module tb_card_display_ctrl;

  localparam logic [6:0] BL   = 7'b1111111;
  localparam logic [6:0] DASH = 7'b0111111;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  logic        load = 1'b0;
  logic [2:0]  load_idx = '0;
  logic [3:0]  load_card = '0;
  logic        clear = 1'b0;
  logic [5:0]  blink_mask = '0;
  logic [41:0] seg_out;
  logic [5:0]  digit_valid;
  logic        busy;

  logic        p_load = 1'b0;
  logic [2:0]  p_idx = '0;
  logic [3:0]  p_card = '0;
  logic [41:0] p_seg;
  logic [5:0]  p_valid;
  logic        p_busy;

  card_display_ctrl #(
    .NUM_DIGITS(6), .REVEAL_CYCLES(4), .BLINK_DIV(3), .SEG_ACTIVE_LOW(1)
  ) dut (
    .slow_clock  (clk),
    .resetb      (resetb),
    .load        (load),
    .load_idx    (load_idx),
    .load_card   (load_card),
    .clear       (clear),
    .blink_mask  (blink_mask),
    .seg_out     (seg_out),
    .digit_valid (digit_valid),
    .busy        (busy)
  );

  card_display_ctrl #(
    .NUM_DIGITS(6), .REVEAL_CYCLES(0), .BLINK_DIV(24), .SEG_ACTIVE_LOW(0)
  ) dut_pol (
    .slow_clock  (clk),
    .resetb      (resetb),
    .load        (p_load),
    .load_idx    (p_idx),
    .load_card   (p_card),
    .clear       (1'b0),
    .blink_mask  (6'b000000),
    .seg_out     (p_seg),
    .digit_valid (p_valid),
    .busy        (p_busy)
  );

  typedef struct packed {
    logic [41:0] seg;
    logic [5:0]  valid;
    logic        busy;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         passed = 0;
  int         total = 0;
  logic [6:0] disp [6];
  logic [5:0] vexp = '0;
  int         bcnt = 0;

  function automatic logic [6:0] glyph(input int c);
    case (c)
      1:  return 7'b0001000;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b1000000;
      11: return 7'b1100001;
      12: return 7'b0011000;
      13: return 7'b0001001;
      default: return BL;
    endcase
  endfunction

  function automatic logic [41:0] pack_disp();
    logic [41:0] r;
    for (int i = 0; i < 6; i++) r[7*i +: 7] = disp[i];
    return r;
  endfunction

  task automatic push(input logic b);
    exp_t x;
    x = {pack_disp(), vexp, b};
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (resetb) bcnt = (bcnt + 1) % 8;
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    repeat (3) step();
    total++;
    if ({seg_out, digit_valid, busy} !== {{42{1'b1}}, 6'b0, 1'b0})
      $display("FAIL reset_in: got %h expected %h", {seg_out, digit_valid, busy},
               {{42{1'b1}}, 6'b0, 1'b0});
    else passed++;
    resetb = 1'b1;
    #1;
    total++;
    if ({seg_out, digit_valid, busy} !== {{42{1'b1}}, 6'b0, 1'b0})
      $display("FAIL reset_out: got %h expected %h", {seg_out, digit_valid, busy},
               {{42{1'b1}}, 6'b0, 1'b0});
    else passed++;
    total++;
    if ({p_seg, p_valid, p_busy} !== 49'h0)
      $display("FAIL reset_pol: got %h expected %h", {p_seg, p_valid, p_busy}, 49'h0);
    else passed++;
  endtask

  task automatic test_load();
    load = 1'b1; load_idx = 3'd2; load_card = 4'd12;
    push(1'b1);
    disp[2] = DASH;
    repeat (3) push(1'b1);
    vexp[2] = 1'b1;
    push(1'b0);
    disp[2] = glyph(12);
    push(1'b0);
    for (int i = 0; i < 6; i++) begin
      step(); load = 1'b0;
      e = exp_q.pop_front();
      total++;
      if ({seg_out, digit_valid, busy} !== e)
        $display("FAIL load[%0d]: got %h expected %h", i, {seg_out, digit_valid, busy}, e);
      else passed++;
    end
  endtask

  task automatic test_invalid();
    load = 1'b1; load_idx = 3'd7; load_card = 4'd5;
    push(1'b0); push(1'b0);
    for (int i = 0; i < 2; i++) begin
      step(); load = 1'b0;
      e = exp_q.pop_front();
      total++;
      if ({seg_out, digit_valid, busy} !== e)
        $display("FAIL bad_idx[%0d]: got %h expected %h", i, {seg_out, digit_valid, busy}, e);
      else passed++;
    end
    load = 1'b1; load_idx = 3'd0; load_card = 4'd14;
    push(1'b1);
    disp[0] = DASH;
    repeat (3) push(1'b1);
    push(1'b0);
    disp[0] = BL;
    push(1'b0);
    for (int i = 0; i < 6; i++) begin
      step(); load = 1'b0;
      e = exp_q.pop_front();
      total++;
      if ({seg_out, digit_valid, busy} !== e)
        $display("FAIL bad_code[%0d]: got %h expected %h", i, {seg_out, digit_valid, busy}, e);
      else passed++;
    end
  endtask

  task automatic test_clear();
    clear = 1'b1; load = 1'b1; load_idx = 3'd1; load_card = 4'd5;
    vexp = '0;
    push(1'b0);
    for (int i = 0; i < 6; i++) disp[i] = BL;
    push(1'b0);
    for (int i = 0; i < 2; i++) begin
      step(); load = 1'b0; clear = 1'b0;
      e = exp_q.pop_front();
      total++;
      if ({seg_out, digit_valid, busy} !== e)
        $display("FAIL clr_prio[%0d]: got %h expected %h", i, {seg_out, digit_valid, busy}, e);
      else passed++;
    end
    load = 1'b1; load_idx = 3'd1; load_card = 4'd5;
    push(1'b1);
    disp[1] = DASH;
    push(1'b1); push(1'b1);
    for (int i = 0; i < 3; i++) begin
      step(); load = 1'b0;
      e = exp_q.pop_front();
      total++;
      if ({seg_out, digit_valid, busy} !== e)
        $display("FAIL first_rev[%0d]: got %h expected %h", i, {seg_out, digit_valid, busy}, e);
      else passed++;
    end
    load = 1'b1; load_idx = 3'd1; load_card = 4'd13;
    repeat (4) push(1'b1);
    vexp[1] = 1'b1;
    push(1'b0);
    disp[1] = glyph(13);
    push(1'b0);
    for (int i = 0; i < 6; i++) begin
      step(); load = 1'b0;
      e = exp_q.pop_front();
      total++;
      if ({seg_out, digit_valid, busy} !== e)
        $display("FAIL reload[%0d]: got %h expected %h", i, {seg_out, digit_valid, busy}, e);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    load = 1'b1; load_idx = 3'd4; load_card = 4'd7;
    push(1'b1);
    step();
    e = exp_q.pop_front();
    total++;
    if ({seg_out, digit_valid, busy} !== e)
      $display("FAIL b2b_first: got %h expected %h", {seg_out, digit_valid, busy}, e);
    else passed++;
    load_idx = 3'd5; load_card = 4'd10;
    disp[4] = DASH;
    push(1'b1);
    disp[5] = DASH;
    push(1'b1); push(1'b1);
    vexp[4] = 1'b1;
    push(1'b1);
    disp[4] = glyph(7);
    vexp[5] = 1'b1;
    push(1'b0);
    disp[5] = glyph(10);
    push(1'b0);
    for (int i = 0; i < 6; i++) begin
      step(); load = 1'b0;
      e = exp_q.pop_front();
      total++;
      if ({seg_out, digit_valid, busy} !== e)
        $display("FAIL b2b[%0d]: got %h expected %h", i, {seg_out, digit_valid, busy}, e);
      else passed++;
    end
  endtask

  task automatic test_blink();
    load = 1'b1; load_idx = 3'd3; load_card = 4'd1;
    push(1'b1);
    disp[3] = DASH;
    repeat (3) push(1'b1);
    vexp[3] = 1'b1;
    push(1'b0);
    for (int i = 0; i < 5; i++) begin
      step(); load = 1'b0;
      e = exp_q.pop_front();
      total++;
      if ({seg_out, digit_valid, busy} !== e)
        $display("FAIL blink_ld[%0d]: got %h expected %h", i, {seg_out, digit_valid, busy}, e);
      else passed++;
    end
    blink_mask = 6'b001000;
    for (int i = 0; i < 16; i++) begin
      // The register samples the phase held before this edge.
      disp[3] = (((bcnt >> 2) & 1) != 0) ? BL : glyph(1);
      push(1'b0);
      step();
      e = exp_q.pop_front();
      total++;
      if ({seg_out, digit_valid, busy} !== e)
        $display("FAIL blink[%0d]: got %h expected %h", i, {seg_out, digit_valid, busy}, e);
      else passed++;
    end
    blink_mask = 6'b000000;
  endtask

  task automatic test_polarity();
    exp_t x;
    p_load = 1'b1; p_idx = 3'd4; p_card = 4'd8;
    x = {42'h0, 6'b010000, 1'b0};
    exp_q.push_back(x);
    x = {42'h0 | (42'h7F << 28), 6'b010000, 1'b0};
    exp_q.push_back(x);
    for (int i = 0; i < 2; i++) begin
      step(); p_load = 1'b0;
      e = exp_q.pop_front();
      total++;
      if ({p_seg, p_valid, p_busy} !== e)
        $display("FAIL polarity[%0d]: got %h expected %h", i, {p_seg, p_valid, p_busy}, e);
      else passed++;
    end
  endtask

  initial begin
    for (int i = 0; i < 6; i++) disp[i] = BL;
    test_reset();
    test_load();
    test_invalid();
    test_clear();
    test_back_to_back();
    test_blink();
    test_polarity();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
